// File: rtl/rw_mem_arb_pkg.sv
// Shared definitions for the 96x8 read/write memory arbiter.
// Holds the sequencer state encoding, the default memory window bounds,
// the requester port indices and the address-window helper.
package rw_mem_arb_pkg;

    // Sequencer states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_ACK     = 2'd3
    } arb_state_e;

    // Default memory window, inclusive at both ends
    localparam logic [7:0] BASE_ADDR_DEFAULT = 8'd128;
    localparam logic [7:0] TOP_ADDR_DEFAULT  = 8'd223;

    // Requester port indices
    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    // Unsigned, inclusive window compare
    function automatic logic addr_in_window(input logic [7:0] addr,
                                            input logic [7:0] base,
                                            input logic [7:0] top);
        return (addr >= base) && (addr <= top);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick (purely combinational).
// Ports:
//   req0, req1  - requests from port 0 (CPU) and port 1 (loader)
//   last_grant  - port granted most recently (register lives in the parent)
//   valid       - at least one request present
//   winner      - selected port; on a tie, the port not granted last
module rr_arb2
    import rw_mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    // Round-robin selection between the two requesters
    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            winner = ~last_grant;
        end else if (req1) begin
            winner = PORT_LOADER;
        end else begin
            winner = PORT_CPU;
        end
    end

endmodule

// File: rtl/rw_mem_arbiter.sv
// Two-port arbiter and sequencer for the 96x8 synchronous read/write memory.
// A winning request is latched in IDLE; in-window addresses go through
// ACCESS -> CAPTURE -> ACK, out-of-window addresses go straight to ACK with err.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   reqN/weN/addrN/wdataN - requester N transaction inputs (N = 0 CPU, 1 loader)
//   ackN/rdataN           - one-cycle completion pulse and read data per port
//   err                   - qualifies ackN as an out-of-range rejection
//   busy                  - high whenever the sequencer is not idle
//   mem_address/mem_WE/mem_data_in - registered drive to the memory
//   mem_data_out          - registered read data from the memory
module rw_mem_arbiter
    import rw_mem_arb_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter logic [7:0] TOP_ADDR  = TOP_ADDR_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       err,
    output logic       busy,
    output logic [7:0] mem_address,
    output logic       mem_WE,
    output logic [7:0] mem_data_in,
    input  logic [7:0] mem_data_out
);

    arb_state_e state_r, state_nxt_s;

    logic       last_grant_r, last_grant_nxt_s;
    logic       gnt_port_r,   gnt_port_nxt_s;
    logic       gnt_we_r,     gnt_we_nxt_s;

    logic       arb_valid_s, arb_winner_s;
    logic       sel_we_s, sel_in_win_s;
    logic [7:0] sel_addr_s, sel_wdata_s;

    logic [7:0] mem_address_r, mem_address_nxt_s;
    logic       mem_we_r,      mem_we_nxt_s;
    logic [7:0] mem_data_in_r, mem_data_in_nxt_s;
    logic       ack0_r, ack0_nxt_s;
    logic       ack1_r, ack1_nxt_s;
    logic [7:0] rdata0_r, rdata0_nxt_s;
    logic [7:0] rdata1_r, rdata1_nxt_s;
    logic       err_r, err_nxt_s;
    logic       busy_r, busy_nxt_s;

    rr_arb2 u_rr_arb2 (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_r),
        .valid      (arb_valid_s),
        .winner     (arb_winner_s)
    );

    // Mux the winning port's request fields and classify its address
    always_comb begin
        if (arb_winner_s == PORT_LOADER) begin
            sel_we_s    = we1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
        sel_in_win_s = addr_in_window(sel_addr_s, BASE_ADDR, TOP_ADDR);
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sequencer next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_valid_s) begin
                    if (sel_in_win_s) begin
                        state_nxt_s = ST_ACCESS;
                    end else begin
                        state_nxt_s = ST_ACK;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS:  state_nxt_s = ST_CAPTURE;
            ST_CAPTURE: state_nxt_s = ST_ACK;
            ST_ACK:     state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of every registered output and of the grant bookkeeping
    always_comb begin
        last_grant_nxt_s  = last_grant_r;
        gnt_port_nxt_s    = gnt_port_r;
        gnt_we_nxt_s      = gnt_we_r;
        mem_address_nxt_s = mem_address_r;
        mem_we_nxt_s      = mem_we_r;
        mem_data_in_nxt_s = mem_data_in_r;
        ack0_nxt_s        = ack0_r;
        ack1_nxt_s        = ack1_r;
        rdata0_nxt_s      = rdata0_r;
        rdata1_nxt_s      = rdata1_r;
        err_nxt_s         = err_r;
        busy_nxt_s        = (state_nxt_s != ST_IDLE);

        case (state_r)
            ST_IDLE: begin
                if (arb_valid_s) begin
                    last_grant_nxt_s = arb_winner_s;
                    gnt_port_nxt_s   = arb_winner_s;
                    gnt_we_nxt_s     = sel_we_s;
                    if (sel_in_win_s) begin
                        mem_address_nxt_s = sel_addr_s;
                        mem_data_in_nxt_s = sel_wdata_s;
                        mem_we_nxt_s      = sel_we_s;
                    end else begin
                        // Rejected: memory signals untouched, answer at once
                        mem_we_nxt_s = 1'b0;
                        err_nxt_s    = 1'b1;
                        if (arb_winner_s == PORT_LOADER) begin
                            ack1_nxt_s   = 1'b1;
                            rdata1_nxt_s = 8'h00;
                        end else begin
                            ack0_nxt_s   = 1'b1;
                            rdata0_nxt_s = 8'h00;
                        end
                    end
                end else begin
                    mem_we_nxt_s = 1'b0;
                end
            end
            ST_ACCESS: begin
                // The memory acts on this edge; write enable lasts one cycle
                mem_we_nxt_s = 1'b0;
            end
            ST_CAPTURE: begin
                // mem_data_out now holds the registered read result
                if (gnt_port_r == PORT_LOADER) begin
                    ack1_nxt_s = 1'b1;
                    if (!gnt_we_r) begin
                        rdata1_nxt_s = mem_data_out;
                    end else begin
                        rdata1_nxt_s = rdata1_r;
                    end
                end else begin
                    ack0_nxt_s = 1'b1;
                    if (!gnt_we_r) begin
                        rdata0_nxt_s = mem_data_out;
                    end else begin
                        rdata0_nxt_s = rdata0_r;
                    end
                end
            end
            ST_ACK: begin
                ack0_nxt_s = 1'b0;
                ack1_nxt_s = 1'b0;
                err_nxt_s  = 1'b0;
            end
            default: begin
                mem_we_nxt_s = 1'b0;
                ack0_nxt_s   = 1'b0;
                ack1_nxt_s   = 1'b0;
                err_nxt_s    = 1'b0;
            end
        endcase
    end

    // Output and grant registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_r  <= PORT_LOADER;
            gnt_port_r    <= PORT_CPU;
            gnt_we_r      <= 1'b0;
            mem_address_r <= 8'd0;
            mem_we_r      <= 1'b0;
            mem_data_in_r <= 8'd0;
            ack0_r        <= 1'b0;
            ack1_r        <= 1'b0;
            rdata0_r      <= 8'd0;
            rdata1_r      <= 8'd0;
            err_r         <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            last_grant_r  <= last_grant_nxt_s;
            gnt_port_r    <= gnt_port_nxt_s;
            gnt_we_r      <= gnt_we_nxt_s;
            mem_address_r <= mem_address_nxt_s;
            mem_we_r      <= mem_we_nxt_s;
            mem_data_in_r <= mem_data_in_nxt_s;
            ack0_r        <= ack0_nxt_s;
            ack1_r        <= ack1_nxt_s;
            rdata0_r      <= rdata0_nxt_s;
            rdata1_r      <= rdata1_nxt_s;
            err_r         <= err_nxt_s;
            busy_r        <= busy_nxt_s;
        end
    end

    assign ack0        = ack0_r;
    assign ack1        = ack1_r;
    assign rdata0      = rdata0_r;
    assign rdata1      = rdata1_r;
    assign err         = err_r;
    assign busy        = busy_r;
    assign mem_address = mem_address_r;
    assign mem_WE      = mem_we_r;
    assign mem_data_in = mem_data_in_r;

endmodule
